// File: rtl/step_controller_pkg.sv
// Shared types and constants for the step controller.
package step_controller_pkg;

  // Width of the completed-instruction counter.
  localparam int STEP_CNT_W = 16;

  // Mode FSM encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEPPING = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

endpackage

// File: rtl/step_controller_debouncer.sv
// switch_debouncer: 2-FF synchroniser followed by a consecutive-sample debounce.
// The level flips only after DEBOUNCE_CYCLES samples in a row disagree with it;
// rise/fall are one-cycle pulses that line up with the level change.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_controller.sv
// step_controller: push-switch to CPU advance enable.
// Short press runs one instruction, long press toggles RUN/STEP.
// Optional build macro STEP_BREAK_EN adds an instruction-pointer breakpoint in RUN.
module step_controller
  import step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  switch,
  input  logic                  phase_last,
`ifdef STEP_BREAK_EN
  input  logic [31:0]           eip,
  input  logic [31:0]           break_addr,
  input  logic                  break_valid,
`endif
  output logic                  cpu_en,
  output logic                  run_mode,
  output logic                  busy,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam logic [CNT_W-1:0] LONG = CNT_W'(LONG_PRESS_CYCLES);

  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hold;
  logic             long_evt;
  logic             short_evt;
  logic             completion;
  state_t           state;
  state_t           next;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (switch),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Hold counter: restarts at each press, counts while pressed, saturates at LONG.
  always_ff @(posedge clk) begin
    if (reset)                      hold <= '0;
    else if (rise)                  hold <= CNT_W'(1);
    else if (level && hold != LONG) hold <= hold + 1'b1;
  end

  // A saturated hold count at release means long_evt already fired for this press.
  assign long_evt   = level && !rise && (hold == LONG - 1'b1);
  assign short_evt  = fall && (hold != LONG);
  assign completion = phase_last && cpu_en;

  // State register plus registered enable and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= next;
      cpu_en     <= (next != IDLE);
      step_count <= step_count + STEP_CNT_W'(completion);
    end
  end

  // Next-state logic.
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (short_evt)     next = STEPPING;
        else if (long_evt) next = RUN;
      end
      STEPPING: if (completion) next = IDLE;
      RUN: begin
`ifdef STEP_BREAK_EN
        if (completion && break_valid && (eip == break_addr)) next = IDLE;
        else if (long_evt)                                     next = DRAIN;
`else
        if (long_evt) next = DRAIN;
`endif
      end
      DRAIN: if (completion) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Mode outputs decoded from the current state.
  always_comb begin
    busy     = (state == STEPPING) || (state == DRAIN);
    run_mode = (state == RUN);
  end

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with a completion scoreboard.
// phase_last is generated on every 15th cpu_en cycle; each completion pushes
// the expected step_count, which is checked on the following cycle.
module tb_step_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        switch;
  logic        phase_last;
  logic        cpu_en;
  logic        run_mode;
  logic        busy;
  logic [15:0] step_count;
`ifdef STEP_BREAK_EN
  logic [31:0] eip         = 32'h0;
  logic [31:0] break_addr  = 32'h10;
  logic        break_valid = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  step_controller #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .CNT_W             (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .switch      (switch),
    .phase_last  (phase_last),
`ifdef STEP_BREAK_EN
    .eip         (eip),
    .break_addr  (break_addr),
    .break_valid (break_valid),
`endif
    .cpu_en      (cpu_en),
    .run_mode    (run_mode),
    .busy        (busy),
    .step_count  (step_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare pending completion, then drive this cycle's phase_last.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) check("step_count", {16'h0, step_count}, {16'h0, sb_q.pop_front()});
    if (cpu_en === 1'b1) begin
      phase_last = (en_cnt % 15 == 14);
      en_cnt++;
      if (phase_last) begin
        exp_cnt = exp_cnt + 16'd1;
        sb_q.push_back(exp_cnt);
      end
    end else begin
      phase_last = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_en(input logic val, input int limit, input string tag);
    int n = 0;
    while (cpu_en !== val && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'h0, cpu_en}, {31'h0, val});
  endtask

  task automatic short_press();
    switch = 1'b1;
    ticks(10);
    switch = 1'b0;
  endtask

  initial begin
    int          n;
    logic [15:0] drain_base;

    reset = 1'b1;
    switch = 1'b0;
    phase_last = 1'b0;
    ticks(3);
    check("rst_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("rst_count", {16'h0, step_count}, 32'h0);
    reset = 1'b0;

    // 1: idle
    ticks(50);
    check("idle_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("idle_run_mode", {31'h0, run_mode}, 32'h0);
    check("idle_count", {16'h0, step_count}, 32'h0);

    // 2: bouncy press then clean release -> one instruction
    for (int i = 0; i < 3; i++) begin
      switch = 1'b1; ticks(2);
      switch = 1'b0; ticks(2);
    end
    switch = 1'b1; ticks(10);
    switch = 1'b0;
    wait_en(1'b1, 40, "step_start");
    check("step_busy", {31'h0, busy}, 32'h1);
    n = 0;
    while (cpu_en === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("step_en_cycles", n, 32'd15);
    check("step_count1", {16'h0, step_count}, 32'h1);
    check("step_busy_done", {31'h0, busy}, 32'h0);
    ticks(30);
    check("step_once", {31'h0, cpu_en}, 32'h0);

    // 3: long press -> RUN, short press in RUN ignored
    switch = 1'b1;
    ticks(20);
    check("run_not_yet", {31'h0, run_mode}, 32'h0);
    ticks(10);
    check("run_mode_on", {31'h0, run_mode}, 32'h1);
    switch = 1'b0;
    ticks(15);
    short_press();
    ticks(15);
    check("run_short_mode", {31'h0, run_mode}, 32'h1);
    check("run_short_en", {31'h0, cpu_en}, 32'h1);
    check("run_short_busy", {31'h0, busy}, 32'h0);
    n = 0;
    while (en_cnt < 61 && n < 200) begin
      tick();
      n++;
    end
    check("run_count4", {16'h0, step_count}, 32'h4);

    // 4: long press in RUN -> DRAIN until next completion
    switch = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("drain_busy", {31'h0, busy}, 32'h1);
    check("drain_run_mode", {31'h0, run_mode}, 32'h0);
    check("drain_en", {31'h0, cpu_en}, 32'h1);
    drain_base = exp_cnt;
    switch = 1'b0;
    wait_en(1'b0, 40, "drain_end");
    check("drain_count", {16'h0, step_count}, {16'h0, drain_base + 16'd1});
    check("drain_busy_done", {31'h0, busy}, 32'h0);
    check("drain_run_off", {31'h0, run_mode}, 32'h0);
    ticks(20);
    check("drain_idle", {31'h0, cpu_en}, 32'h0);

    // 5: counter wrap
    force dut.step_count = 16'hFFFF;
    tick();
    release dut.step_count;
    exp_cnt = 16'hFFFF;
    short_press();
    wait_en(1'b1, 40, "wrap_start");
    wait_en(1'b0, 40, "wrap_end");
    check("wrap_zero", {16'h0, step_count}, 32'h0);

    // 6: reset mid-STEPPING
    short_press();
    wait_en(1'b1, 40, "rst_step_start");
    ticks(7);
    reset = 1'b1;
    tick();
    check("midrst_en", {31'h0, cpu_en}, 32'h0);
    check("midrst_run", {31'h0, run_mode}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_count", {16'h0, step_count}, 32'h0);
    reset = 1'b0;
    sb_q.delete();
    exp_cnt = 16'h0;
    en_cnt = 0;
    ticks(20);
    check("post_rst_idle", {31'h0, cpu_en}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
